// File: rtl/fb_pkg.sv
// Shared constants and grant encoding for the framebuffer BRAM arbiter.
//   ADDR_W     : BRAM address width
//   DATA_W     : pixel width (RGB444)
//   FB_WORDS   : number of valid framebuffer words (0..FB_WORDS-1)
//   FIFO_DEPTH : write-buffer depth, power of two
package fb_pkg;
    localparam int ADDR_W     = 17;
    localparam int DATA_W     = 12;
    localparam int FB_WORDS   = 76800;
    localparam int FIFO_DEPTH = 4;

    // What the single BRAM port does in a given cycle.
    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;
endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write buffer holding {addr, data} words for the arbiter.
// Ports:
//   clk, rst_n : clock, async active-low reset (flushes pointers/level)
//   i_push     : enqueue i_din (ignored when full)
//   i_din      : word to enqueue
//   i_pop      : dequeue head (ignored when empty)
//   o_dout     : head word (valid when not empty)
//   o_level    : number of buffered words
//   o_full     : level == DEPTH
//   o_empty    : level == 0
module fb_wr_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == LW'(DEPTH));
    assign o_empty = (r_level == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dout  = r_mem[r_rptr];
    assign o_level = r_level;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset; the flushed pointers make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_din;
    end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer BRAM arbiter: display reads always win, writer
// traffic is buffered in a small FIFO and drained in idle read cycles.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   i_rd_req/i_rd_addr          : display read, one word per cycle, never stalled
//   o_rd_data/o_rd_valid        : read return, 2 cycles after i_rd_req
//   i_wr_req/i_wr_addr/i_wr_data: writer request, accepted when o_wr_ready
//   o_wr_ready                  : write buffer not full
//   i_ovf_clr                   : clears sticky o_wr_ovf / o_wr_oor
//   o_wr_ovf                    : sticky, write offered while not ready
//   o_wr_oor                    : sticky, accepted write out of range (dropped)
//   o_fifo_level                : buffered write count
//   o_bram_en/we/addr/din       : registered BRAM port controls
//   i_bram_dout                 : BRAM read data, 1-cycle latency
module fb_arbiter #(
    parameter int ADDR_W     = fb_pkg::ADDR_W,
    parameter int DATA_W     = fb_pkg::DATA_W,
    parameter int FB_WORDS   = fb_pkg::FB_WORDS,
    parameter int FIFO_DEPTH = fb_pkg::FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_rd_req,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_rd_valid,
    input  logic                          i_wr_req,
    input  logic [ADDR_W-1:0]             i_wr_addr,
    input  logic [DATA_W-1:0]             i_wr_data,
    output logic                          o_wr_ready,
    input  logic                          i_ovf_clr,
    output logic                          o_wr_ovf,
    output logic                          o_wr_oor,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_bram_en,
    output logic                          o_bram_we,
    output logic [ADDR_W-1:0]             o_bram_addr,
    output logic [DATA_W-1:0]             o_bram_din,
    input  logic [DATA_W-1:0]             i_bram_dout
);
    import fb_pkg::*;

    localparam int WORD_W = ADDR_W + DATA_W;
    // One extra bit so FB_WORDS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(FB_WORDS);

    grant_e                      w_grant;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [WORD_W-1:0]           w_fifo_dout;
    logic [ADDR_W-1:0]           w_q_addr;
    logic [DATA_W-1:0]           w_q_data;
    logic                        w_in_range;
    logic                        w_wr_acc;
    logic                        w_push;
    logic                        w_pop;

    logic                        r_bram_en;
    logic                        r_bram_we;
    logic [ADDR_W-1:0]           r_bram_addr;
    logic [DATA_W-1:0]           r_bram_din;
    logic [1:0]                  r_rd_pipe;   // [0]: BRAM read issued, [1]: data at BRAM output
    logic [DATA_W-1:0]           r_rd_hold;
    logic                        r_wr_ovf;
    logic                        r_wr_oor;

    // Grant decision: reads first, then buffered writes.
    always_comb begin
        w_grant = GNT_IDLE;
        if (i_rd_req)           w_grant = GNT_READ;
        else if (!w_fifo_empty) w_grant = GNT_WRITE;
    end

    // Ready comes purely from registered FIFO state: a pop in the same
    // cycle does not make room for a write offered while full.
    assign o_wr_ready = !w_fifo_full;
    assign w_in_range = ({1'b0, i_wr_addr} < ADDR_LIMIT);
    assign w_wr_acc   = i_wr_req && o_wr_ready;
    assign w_push     = w_wr_acc && w_in_range;
    assign w_pop      = (w_grant == GNT_WRITE);
    assign w_q_addr   = w_fifo_dout[WORD_W-1:DATA_W];
    assign w_q_data   = w_fifo_dout[DATA_W-1:0];

    fb_wr_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({i_wr_addr, i_wr_data}),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_level (o_fifo_level),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bram_en   <= 1'b0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
            r_rd_pipe   <= '0;
            r_rd_hold   <= '0;
            r_wr_ovf    <= 1'b0;
            r_wr_oor    <= 1'b0;
        end else begin
            r_bram_en <= (w_grant != GNT_IDLE);
            r_bram_we <= (w_grant == GNT_WRITE);
            // Address/data hold their last value on idle cycles.
            case (w_grant)
                GNT_READ:  r_bram_addr <= i_rd_addr;
                GNT_WRITE: begin
                    r_bram_addr <= w_q_addr;
                    r_bram_din  <= w_q_data;
                end
                default: ;
            endcase
            r_rd_pipe <= {r_rd_pipe[0], (w_grant == GNT_READ)};
            if (r_rd_pipe[1]) r_rd_hold <= i_bram_dout;
            // A new event in the same cycle as a clear keeps the flag set.
            r_wr_ovf <= (i_wr_req && !o_wr_ready) || (r_wr_ovf && !i_ovf_clr);
            r_wr_oor <= (w_wr_acc && !w_in_range) || (r_wr_oor && !i_ovf_clr);
        end
    end

    // The BRAM output register is the read data register: present it
    // directly while a read completes, otherwise hold the last word.
    assign o_rd_valid  = r_rd_pipe[1];
    assign o_rd_data   = r_rd_pipe[1] ? i_bram_dout : r_rd_hold;
    assign o_bram_en   = r_bram_en;
    assign o_bram_we   = r_bram_we;
    assign o_bram_addr = r_bram_addr;
    assign o_bram_din  = r_bram_din;
    assign o_wr_ovf    = r_wr_ovf;
    assign o_wr_oor    = r_wr_oor;
endmodule

// File: tb/tb_fb_arbiter.sv
module tb_fb_arbiter;
    localparam int AW  = 17;
    localparam int DW  = 12;
    localparam int FBW = 76800;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          ovf_clr = 1'b0;
    logic          wr_ovf;
    logic          wr_oor;
    logic [2:0]    fifo_level;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;

    always #5 clk = ~clk;

    fb_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_req     (rd_req),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .i_wr_req     (wr_req),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .i_ovf_clr    (ovf_clr),
        .o_wr_ovf     (wr_ovf),
        .o_wr_oor     (wr_oor),
        .o_fifo_level (fifo_level),
        .o_bram_en    (bram_en),
        .o_bram_we    (bram_we),
        .o_bram_addr  (bram_addr),
        .o_bram_din   (bram_din),
        .i_bram_dout  (bram_dout)
    );

    // BRAM: read-first, 1-cycle read latency.
    logic [DW-1:0] bram [FBW];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram[bram_addr] <= bram_din;
            bram_dout <= bram[bram_addr];
        end
    end

    // Reference model: framebuffer contents as seen in grant order,
    // a queue of pending writes, and a two-deep read-return delay line.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    logic [DW-1:0] ref_mem [FBW];
    wr_t           wq[$];
    logic          m_en, m_we, m_ovf, m_oor, m_rv0, m_rv1;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_din, m_rd0, m_rd1, m_hold;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        wq.delete();
        m_en = 0; m_we = 0; m_ovf = 0; m_oor = 0; m_rv0 = 0; m_rv1 = 0;
        m_addr = '0; m_din = '0; m_rd0 = '0; m_rd1 = '0; m_hold = '0;
    endtask

    task automatic check_all();
        chk("wr_ready",   wr_ready,   (wq.size() < 4));
        chk("fifo_level", fifo_level, wq.size());
        chk("wr_ovf",     wr_ovf,     m_ovf);
        chk("wr_oor",     wr_oor,     m_oor);
        chk("bram_en",    bram_en,    m_en);
        chk("bram_we",    bram_we,    m_we);
        chk("bram_addr",  bram_addr,  m_addr);
        chk("bram_din",   bram_din,   m_din);
        chk("rd_valid",   rd_valid,   m_rv1);
        chk("rd_data",    rd_data,    m_rv1 ? m_rd1 : m_hold);
    endtask

    task automatic check_reset();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data",  rd_data, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_level",    fifo_level, 0);
        chk("rst_ovf",      wr_ovf, 0);
        chk("rst_oor",      wr_oor, 0);
        chk("rst_en",       bram_en, 0);
        chk("rst_we",       bram_we, 0);
        chk("rst_addr",     bram_addr, 0);
        chk("rst_din",      bram_din, 0);
    endtask

    task automatic model_step(input int rr, input int ra, input int wr, input int wa,
                              input int wd, input int clr);
        bit ready;
        ready = (wq.size() < 4);
        if (m_rv1) m_hold = m_rd1;
        m_rv1 = m_rv0;
        m_rd1 = m_rd0;
        m_rv0 = (rr != 0);
        if (rr != 0) m_rd0 = ref_mem[ra];
        if (rr != 0) begin
            m_en = 1; m_we = 0; m_addr = AW'(ra);
        end else if (wq.size() > 0) begin
            wr_t e;
            e = wq.pop_front();
            m_en = 1; m_we = 1; m_addr = e.a; m_din = e.d;
            ref_mem[e.a] = e.d;
        end else begin
            m_en = 0; m_we = 0;
        end
        if (wr != 0 && ready && wa < FBW) wq.push_back({AW'(wa), DW'(wd)});
        m_ovf = (wr != 0 && !ready) || (m_ovf && clr == 0);
        m_oor = (wr != 0 && ready && wa >= FBW) || (m_oor && clr == 0);
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic cyc(input int rr, input int ra, input int wr, input int wa,
                       input int wd, input int clr);
        rd_req = (rr != 0); rd_addr = AW'(ra);
        wr_req = (wr != 0); wr_addr = AW'(wa); wr_data = DW'(wd);
        ovf_clr = (clr != 0);
        #1;
        check_all();
        model_step(rr, ra, wr, wa, wd, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < FBW; i++) begin
            bram[i]    = DW'(i * 7);
            ref_mem[i] = DW'(i * 7);
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset();
        model_reset();
        rst_n = 1'b1;
        idle(2);

        // Single write, then readback.
        cyc(0, 0, 1, 5, 'h123, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("w5_we", bram_we, 1);
        chk("w5_addr", bram_addr, 5);
        chk("w5_din", bram_din, 'h123);
        idle(2);
        cyc(1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("r5_valid", rd_valid, 1);
        chk("r5_data", rd_data, 'h123);
        idle(2);

        // Reads hold the port for 10 cycles while 5 writes are offered.
        for (int i = 0; i < 10; i++) cyc(1, 5 + i, (i < 5) ? 1 : 0, 20 + i, 'h200 + i, 0);
        chk("hold_level", fifo_level, 4);
        chk("hold_ready", wr_ready, 0);
        chk("hold_ovf", wr_ovf, 1);
        idle(8);

        // Out-of-range write, then clear.
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, FBW, 'h055, 0);
        chk("oor_flag", wr_oor, 1);
        chk("oor_level", fifo_level, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("clr_oor", wr_oor, 0);
        chk("clr_ovf", wr_ovf, 0);

        // Full FIFO, pop and write offered in the same cycle.
        for (int i = 0; i < 4; i++) cyc(1, 3, 1, 40 + i, 'h300 + i, 0);
        chk("full_level", fifo_level, 4);
        cyc(0, 0, 1, 50, 'h077, 0);
        chk("popfull_level", fifo_level, 3);
        idle(6);

        // Reset with three buffered writes and a read in flight.
        cyc(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 7, 1, 60 + i, 'h400 + i, 0);
        rd_req = 0; wr_req = 0; ovf_clr = 0;
        rst_n = 1'b0;
        #1;
        check_reset();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(6);
        for (int i = 60; i < 63; i++) chk("rst_nowrite", bram[i], DW'(i * 7));

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int rr, ra, wr, wa, wd, clr;
            rr  = ($urandom_range(0, 99) < 40) ? 1 : 0;
            ra  = $urandom_range(0, 31);
            wr  = ($urandom_range(0, 99) < 50) ? 1 : 0;
            wa  = ($urandom_range(0, 15) == 0) ? FBW + $urandom_range(0, 3) : $urandom_range(0, 31);
            wd  = $urandom_range(0, 4095);
            clr = ($urandom_range(0, 19) == 0) ? 1 : 0;
            cyc(rr, ra, wr, wa, wd, clr);
        end
        idle(8);
        for (int i = 0; i < 32; i++) chk("final_mem", bram[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, BRAM address width.
REQ-002 Parameter DATA_W, default 12, pixel width (RGB444).
REQ-003 Parameter FB_WORDS, default 76800, valid address range 0..FB_WORDS-1.
REQ-004 Parameter FIFO_DEPTH, default 4, write-buffer depth (power of two).
REQ-005 clk  in  1  system clock; the only clock in the block.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 rd_req  in  1  display read request, one word per cycle.
REQ-008 rd_addr  in  ADDR_W  display read address.
REQ-009 rd_data  out  DATA_W  read data, registered.
REQ-010 rd_valid  out  1  rd_data qualifier.
REQ-011 wr_req  in  1  writer request.
REQ-012 wr_addr  in  ADDR_W  write address.
REQ-013 wr_data  in  DATA_W  write data.
REQ-014 wr_ready  out  1  write buffer not full.
REQ-015 ovf_clr  in  1  clears sticky error flags.
REQ-016 wr_ovf  out  1  sticky: wr_req seen while wr_ready low.
REQ-017 wr_oor  out  1  sticky: write address >= FB_WORDS, write dropped.
REQ-018 fifo_level  out  clog2(FIFO_DEPTH)+1  buffered write count.
REQ-019 bram_en, bram_we  out  1 each  BRAM port controls, registered.
REQ-020 bram_addr  out  ADDR_W; bram_din  out  DATA_W; bram_dout  in  DATA_W (1-cycle BRAM read latency).

Function
REQ-021 Single BRAM port shared; each cycle exactly one grant: READ if rd_req, else WRITE if fifo_level>0, else IDLE.
REQ-022 Reads are never stalled; reads always win over buffered writes.
REQ-023 Grant registered: bram_en/bram_we/bram_addr/bram_din driven in the cycle after the grant decision.
REQ-024 rd_data/rd_valid valid exactly 2 cycles after the cycle rd_req was high; back-to-back reads stream at 1 word/cycle.
REQ-025 rd_valid low whenever no read completes; rd_data holds last value.
REQ-026 Write accepted when wr_req && wr_ready; wr_ready = (fifo_level < FIFO_DEPTH) from registered state, no same-cycle bypass when full.
REQ-027 Simultaneous push and pop: accepted only if not full at cycle start; level unchanged.
REQ-028 wr_req with wr_ready low: write discarded, wr_ovf set.
REQ-029 Accepted write with wr_addr >= FB_WORDS: not enqueued, wr_oor set; wr_ready unaffected.
REQ-030 Writes commit to BRAM in acceptance order.
REQ-031 Read of an address with a pending buffered write returns pre-write BRAM contents (no forwarding).
REQ-032 ovf_clr clears wr_ovf/wr_oor; set in same cycle as clear wins.
REQ-033 bram_we high only on WRITE grant; bram_en high on READ or WRITE.

Reset
REQ-034 rst_n low: FIFO flushed, fifo_level=0, wr_ready=1, rd_valid=0, rd_data=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, flags 0.
REQ-035 Reset mid-operation: in-flight reads and buffered writes discarded, no BRAM write after deassertion until a new accepted write.

Structure
REQ-036 Shared package fb_pkg holds ADDR_W, DATA_W, FB_WORDS, FIFO_DEPTH and grant encoding (IDLE, READ, WRITE).
REQ-037 Write buffer is sub-module fb_wr_fifo (synchronous FIFO, addr+data word, level output).

Verification
REQ-038 Single write 0x123 to addr 5, rd_req idle -> bram_we=1, bram_addr=5, bram_din=0x123 two cycles after wr_req.
REQ-039 Read addr 5 after REQ-038 -> rd_valid=1, rd_data=0x123 exactly 2 cycles after rd_req.
REQ-040 rd_req held 10 cycles while 5 writes offered -> 4 accepted, wr_ready low, wr_ovf=1, no bram_we during reads; 4 writes drain in order once rd_req drops.
REQ-041 Write addr 76800 -> no enqueue, wr_oor=1, fifo_level unchanged; ovf_clr -> flags 0.
REQ-042 Full FIFO plus simultaneous pop and wr_req -> write rejected, fifo_level 4->3.
REQ-043 rst_n asserted with 3 buffered writes -> all outputs at REQ-034 values, no bram_we after release.
